ahb_arbiter_master: RTL
=======================

// Module: ahb_arbiter_master
// PURPOSE
//  Per-slave AHB arbiter: picks which of CHANNEL_NUM masters owns the slave port and drives the
//  one-hot sel of the master-side payload mux (addr_sel) plus a data-phase-aligned copy (data_sel).
//  Burst-aware (fixed-length and INCR), honours HMASTLOCK, changes grant only on HREADY boundaries.
//  Idle bus = all-zero sel, so the mux outputs zeros, i.e. HTRANS=IDLE.
// PARAMETERS
//  CHANNEL_NUM  4                     number of requesting masters
//  MASTER_W     $clog2(CHANNEL_NUM)   width of hmaster
// PORTS
//  HCLK       in   1                        clock; all flops on posedge
//  HRESETn    in   1                        asynchronous active-low reset
//  hreq       in   CHANNEL_NUM              per-master bus request
//  hlock      in   CHANNEL_NUM              per-master HMASTLOCK request
//  htrans     in   CHANNEL_NUM x 2          per-master HTRANS (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3)
//  hburst     in   CHANNEL_NUM x 3          per-master HBURST
//  hready     in   1                        slave HREADYOUT (transfer accepted when 1)
//  addr_sel   out  CHANNEL_NUM              one-hot/zero address-phase grant -> mux sel
//  data_sel   out  CHANNEL_NUM              addr_sel delayed one accepted beat -> HWDATA mux sel
//  hmaster    out  MASTER_W                 index of addr_sel owner (0 when addr_sel==0)
//  hmastlock  out  1                        hlock[owner] registered with addr_sel
// BEHAVIOUR
//  Reset: addr_sel=0, data_sel=0, hmaster=0, hmastlock=0, beat_cnt=0, state=IDLE, rr_ptr=0.
//  All state updates only on posedge HCLK with hready=1; hready=0 freezes every register.
//  data_sel <= addr_sel on every hready=1 edge (one-beat pipeline, stays aligned under wait states).
//  States: IDLE (addr_sel==0), OWNED (owner set, no fixed burst open), BURST (fixed burst open).
//  Owner signals (ht, hb) = htrans/hburst of the addr_sel bit.
//  Burst length L from hb: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=undefined.
//  OWNED, ht=NONSEQ, L>1 fixed -> beat_cnt=L-1, go BURST. BURST: ht=SEQ decrements beat_cnt;
//   ht=BUSY holds; beat_cnt reaching 0 -> arbitration point. NONSEQ/IDLE in BURST = early
//   termination -> beat_cnt=0, treat as arbitration point.
//  Arbitration point (hready=1 and any of): state IDLE; OWNED and ht=IDLE; OWNED, ht=NONSEQ, L=1;
//   OWNED, hb=INCR and hreq[owner]=0; BURST last SEQ accepted.
//  Lock: hlock[owner]=1 suppresses every arbitration point; owner keeps grant until hlock drops.
//  At an arbitration point the new addr_sel is registered: winner among hreq (may be same master);
//   no requests -> addr_sel=0, state IDLE. Latency hreq->addr_sel = 1 cycle from the IDLE state.
//  hreq rising mid-burst is ignored until the arbitration point; no pre-emption ever.
//  Owner dropping hreq mid fixed burst: grant held until the burst ends (AHB rule).
//  Asynchronous reset mid-burst: all outputs to 0 immediately; no burst state survives.
//  Simultaneous requests: resolved by the priority scheme below, single-cycle decision.
// CONFIGURATION
//  AHB_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at rr_ptr, rr_ptr <= winner+1
//   (mod CHANNEL_NUM) on every grant to a requesting master.
//  Not defined: fixed priority, lowest index wins; rr_ptr absent.
// TESTING
//  Single master: hreq[2]=1, hready=1, SINGLE NONSEQ -> addr_sel=4'b0100 next cycle,
//   data_sel=4'b0100 one cycle later, then 0 when hreq drops.
//  INCR4 owned by M1, hreq[0] raised on beat 2 -> addr_sel stays 4'b0010 for 4 beats, then 4'b0001.
//  Wait states: hready=0 for 3 cycles mid INCR8 -> addr_sel, data_sel, beat_cnt frozen; burst
//   still exactly 8 accepted beats.
//  Lock: hlock[3]=1 with two INCR4 bursts back-to-back, hreq[0]=1 -> addr_sel=4'b1000 throughout,
//   hmastlock=1; grant moves to M0 only after hlock[3]=0.
//  Contention hreq=4'b1111 continuously, SINGLE transfers: RR_EN -> grants 0,1,2,3,0...;
//   without -> M0 every time.
//  HRESETn pulsed low mid WRAP8 -> addr_sel=data_sel=0, hmastlock=0 asynchronously; after release
//   first grant follows normal arbitration.

Source files
------------

// File: rtl/ahb_arbiter_master.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_master
//   Per-slave AHB arbiter. Chooses which of CHANNEL_NUM masters owns the slave
//   port and drives the one-hot select of the master-side payload mux
//   (addr_sel) plus a copy delayed by one accepted beat for the HWDATA mux
//   (data_sel). Burst aware (fixed-length and INCR), honours HMASTLOCK, and
//   only moves the grant on HREADY boundaries. An all-zero select means an
//   idle bus: the mux outputs zeros, i.e. HTRANS=IDLE.
//
//   Build option: AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//   (search starts at a rotating pointer); otherwise fixed priority with the
//   lowest index winning.
//
// Ports
//   HCLK       in   clock, all flops on posedge
//   HRESETn    in   asynchronous active-low reset
//   hreq       in   [CHANNEL_NUM]    per-master bus request
//   hlock      in   [CHANNEL_NUM]    per-master HMASTLOCK request
//   htrans     in   [2*CHANNEL_NUM]  per-master HTRANS, master i at [2i+:2]
//   hburst     in   [3*CHANNEL_NUM]  per-master HBURST, master i at [3i+:3]
//   hready     in   slave HREADYOUT; 0 freezes every register
//   addr_sel   out  [CHANNEL_NUM]    one-hot/zero address-phase grant
//   data_sel   out  [CHANNEL_NUM]    addr_sel delayed one accepted beat
//   hmaster    out  [MASTER_W]       index of the addr_sel owner (0 if none)
//   hmastlock  out  hlock of the owner, registered with addr_sel
// ---------------------------------------------------------------------------
module ahb_arbiter_master #(
  parameter int CHANNEL_NUM = 4,
  parameter int MASTER_W    = $clog2(CHANNEL_NUM)
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [CHANNEL_NUM-1:0]   hreq,
  input  logic [CHANNEL_NUM-1:0]   hlock,
  input  logic [2*CHANNEL_NUM-1:0] htrans,
  input  logic [3*CHANNEL_NUM-1:0] hburst,
  input  logic                     hready,
  output logic [CHANNEL_NUM-1:0]   addr_sel,
  output logic [CHANNEL_NUM-1:0]   data_sel,
  output logic [MASTER_W-1:0]      hmaster,
  output logic                     hmastlock
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_beat_cnt, w_beat_cnt_nxt;
  logic [CHANNEL_NUM-1:0] r_addr_sel, w_addr_sel_nxt;
  logic [CHANNEL_NUM-1:0] r_data_sel;
  logic [MASTER_W-1:0]    r_hmaster, w_hmaster_nxt;
  logic                   r_hmastlock, w_hmastlock_nxt;

  // owner-side view of the request bundle
  logic [1:0]             w_ht;
  logic [2:0]             w_hb;
  logic                   w_own_req;
  logic                   w_own_lock;

  // burst decode
  logic                   w_single;
  logic                   w_incr;
  logic                   w_fixed_multi;
  logic [3:0]             w_len_m1;

  // arbitration
  logic                   w_arb;
  logic                   w_take;
  logic                   w_found;
  logic [MASTER_W-1:0]    w_win;

  // -------------------------------------------------------------------------
  // Owner signal mux (addr_sel is one-hot or zero, so OR-reduction suffices)
  // -------------------------------------------------------------------------
  always_comb begin
    w_ht       = '0;
    w_hb       = '0;
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (r_addr_sel[i]) begin
        w_ht       = w_ht | htrans[2*i +: 2];
        w_hb       = w_hb | hburst[3*i +: 3];
        w_own_req  = w_own_req | hreq[i];
        w_own_lock = w_own_lock | hlock[i];
      end
    end
  end

  always_comb begin
    w_single      = (w_hb == 3'd0);
    w_incr        = (w_hb == 3'd1);
    w_fixed_multi = (w_hb[2:1] != 2'b00);
    case (w_hb[2:1])
      2'b01:   w_len_m1 = 4'd3;
      2'b10:   w_len_m1 = 4'd7;
      2'b11:   w_len_m1 = 4'd15;
      default: w_len_m1 = 4'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Winner selection among current requests
  // -------------------------------------------------------------------------
`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MASTER_W-1:0]      r_rr_ptr;
  logic [2*CHANNEL_NUM-1:0] w_req_rot;
  logic [MASTER_W:0]        w_rr_sum;

  // rotate a doubled copy so the scan below can use constant indices
  always_comb begin
    w_req_rot = {hreq, hreq} >> r_rr_ptr;
    w_found   = 1'b0;
    w_win     = '0;
    w_rr_sum  = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found  = 1'b1;
        w_rr_sum = {1'b0, r_rr_ptr} + (MASTER_W+1)'(k);
        if (w_rr_sum >= (MASTER_W+1)'(CHANNEL_NUM))
          w_rr_sum = w_rr_sum - (MASTER_W+1)'(CHANNEL_NUM);
        w_win = w_rr_sum[MASTER_W-1:0];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rr_ptr <= '0;
    end else if (hready && w_take && w_found) begin
      r_rr_ptr <= (w_win == MASTER_W'(CHANNEL_NUM-1)) ? '0 : w_win + MASTER_W'(1);
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
      if (!w_found && hreq[k]) begin
        w_found = 1'b1;
        w_win   = MASTER_W'(k);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_addr_sel  <= '0;
      r_data_sel  <= '0;
      r_hmaster   <= '0;
      r_hmastlock <= 1'b0;
    end else if (hready) begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_addr_sel  <= w_addr_sel_nxt;
      r_data_sel  <= r_addr_sel;
      r_hmaster   <= w_hmaster_nxt;
      r_hmastlock <= w_hmastlock_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state / beat counter / arbitration point detection
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_arb          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arb = 1'b1;
      end
      ST_OWNED: begin
        if (w_ht == TR_NONSEQ && w_fixed_multi) begin
          w_beat_cnt_nxt = w_len_m1;
          w_state_nxt    = ST_BURST;
        end else if (w_ht == TR_IDLE || (w_ht == TR_NONSEQ && w_single) ||
                     (w_incr && !w_own_req)) begin
          w_arb = 1'b1;
        end
      end
      ST_BURST: begin
        case (w_ht)
          TR_SEQ: begin
            if (r_beat_cnt <= 4'd1) begin
              w_beat_cnt_nxt = '0;
              w_state_nxt    = ST_OWNED;
              w_arb          = 1'b1;
            end else begin
              w_beat_cnt_nxt = r_beat_cnt - 4'd1;
            end
          end
          TR_BUSY: ;
          default: begin
            // early termination; a locked owner restarting a fixed burst
            // keeps the new burst tracked since no arbitration can happen
            w_beat_cnt_nxt = '0;
            w_state_nxt    = ST_OWNED;
            w_arb          = 1'b1;
            if (w_own_lock && w_ht == TR_NONSEQ && w_fixed_multi) begin
              w_beat_cnt_nxt = w_len_m1;
              w_state_nxt    = ST_BURST;
            end
          end
        endcase
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase

    w_take = w_arb && !w_own_lock;
    if (w_take) begin
      w_beat_cnt_nxt = '0;
      w_state_nxt    = w_found ? ST_OWNED : ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: grant outputs (registered alongside the state)
  // -------------------------------------------------------------------------
  always_comb begin
    w_addr_sel_nxt = r_addr_sel;
    w_hmaster_nxt  = r_hmaster;
    if (w_take) begin
      w_addr_sel_nxt = '0;
      w_hmaster_nxt  = '0;
      if (w_found) begin
        w_addr_sel_nxt[w_win] = 1'b1;
        w_hmaster_nxt         = w_win;
      end
    end
    w_hmastlock_nxt = |(w_addr_sel_nxt & hlock);
  end

  assign addr_sel  = r_addr_sel;
  assign data_sel  = r_data_sel;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

endmodule
